// File: rtl/memory_ctrl_wb_cache.sv
// Write-back, direct-mapped cache controller between a core memory port and a slow word memory.
// Multi-word refill, dirty-line write-back, whole-cache flush, saturating hit/miss counters.
module memory_ctrl_wb_cache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           datain,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [3:0]            byte_select_vector,
  input  logic                  flush,
  output logic                  memReady,
  output logic [31:0]           dataout,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [2:0]            state_dbg
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - 2 - INDEX_BITS - OFFSET_BITS;

  // Memory handshake: mem_req rises and holds with mem_we/mem_addr/mem_wdata stable
  // until the one-cycle mem_ack; the word completes on the edge where both are high.
  typedef enum logic [2:0] {S_IDLE, S_WB, S_REFILL, S_FLUSH, S_FLUSH_WB} state_t;

  state_t                     state;
  logic [31:0]                data_mem [LINES*WORDS];
  logic [TAG_BITS-1:0]        tag_mem  [LINES];
  logic [LINES-1:0]           valid;
  logic [LINES-1:0]           dirty;
  logic [INDEX_BITS-1:0]      scan_idx;
  logic [OFFSET_BITS-1:0]     word;
  logic                       retry;

  logic [TAG_BITS-1:0]        req_tag;
  logic [INDEX_BITS-1:0]      idx;
  logic [OFFSET_BITS-1:0]     off;
  logic [INDEX_BITS-1:0]      wb_line;
  logic                       req;
  logic                       hit;
  logic                       lookup_hit;
  logic                       unused_addr_bits;

  assign req_tag          = address[ADDR_WIDTH-1 -: TAG_BITS];
  assign idx              = address[2+OFFSET_BITS +: INDEX_BITS];
  assign off              = address[2 +: OFFSET_BITS];
  assign unused_addr_bits = ^address[1:0];
  assign req              = ren | wen;
  assign hit              = valid[idx] && (tag_mem[idx] == req_tag);
  assign lookup_hit       = (state == S_IDLE) && req && hit;
  assign memReady         = (state == S_IDLE) && (!req || hit);
  assign dataout          = lookup_hit ? data_mem[{idx, off}] : 32'h0;
  assign state_dbg        = state;
  assign wb_line          = (state == S_FLUSH_WB) ? scan_idx : idx;

  always_comb begin
    mem_we    = (state == S_WB) || (state == S_FLUSH_WB);
    mem_addr  = {req_tag, idx, word};
    mem_wdata = data_mem[{wb_line, word}];
    if (mem_we) mem_addr = {tag_mem[wb_line], wb_line, word};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      valid      <= '0;
      dirty      <= '0;
      mem_req    <= 1'b0;
      word       <= '0;
      scan_idx   <= '0;
      retry      <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          retry <= 1'b0;
          if (req) begin
            if (hit) begin
              // The lookup replayed after a refill is not a fresh hit.
              if (!retry && hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
              if (wen) dirty[idx] <= 1'b1;
            end else begin
              if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
              word  <= '0;
              state <= (valid[idx] && dirty[idx]) ? S_WB : S_REFILL;
            end
          end else if (flush) begin
            scan_idx <= '0;
            state    <= S_FLUSH;
          end
        end
        S_WB, S_REFILL, S_FLUSH_WB: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            word    <= word + OFFSET_BITS'(1);
            if (word == '1) begin
              case (state)
                S_WB: state <= S_REFILL;
                S_REFILL: begin
                  valid[idx] <= 1'b1;
                  dirty[idx] <= 1'b0;
                  retry      <= 1'b1;
                  state      <= S_IDLE;
                end
                default: begin
                  // Line is clean now; the scan step below invalidates it.
                  dirty[scan_idx] <= 1'b0;
                  state           <= S_FLUSH;
                end
              endcase
            end
          end
        end
        S_FLUSH: begin
          if (dirty[scan_idx]) begin
            word  <= '0;
            state <= S_FLUSH_WB;
          end else begin
            valid[scan_idx] <= 1'b0;
            if (scan_idx == '1) state <= S_IDLE;
            else scan_idx <= scan_idx + INDEX_BITS'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data and tag arrays are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (lookup_hit && wen) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_select_vector[b]) data_mem[{idx, off}][8*b +: 8] <= datain[8*b +: 8];
        end
      end
      if (state == S_REFILL && mem_req && mem_ack) begin
        data_mem[{idx, word}] <= mem_rdata;
        if (word == '1) tag_mem[idx] <= req_tag;
      end
    end
  end
endmodule

// File: tb/tb_memory_ctrl_wb_cache.sv
// Directed bench for memory_ctrl_wb_cache: memory responder, read/memory scoreboards, counter checks.
module tb_memory_ctrl_wb_cache;
  localparam int AW = 32;
  localparam int CW = 4;
  localparam int MW = 63;

  logic          clk, reset;
  logic [AW-1:0] address;
  logic [31:0]   datain, dataout, mem_wdata, mem_rdata;
  logic          wen, ren, flush, memReady, mem_req, mem_we, mem_ack;
  logic [3:0]    byte_select_vector;
  logic [AW-3:0] mem_addr;
  logic [CW-1:0] hit_count, miss_count;
  logic [2:0]    state_dbg;

  memory_ctrl_wb_cache #(.ADDR_WIDTH(AW), .INDEX_BITS(4), .OFFSET_BITS(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .address(address), .datain(datain), .wen(wen), .ren(ren),
    .byte_select_vector(byte_select_vector), .flush(flush), .memReady(memReady),
    .dataout(dataout), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  logic [MW-1:0] exp_q[$];
  logic [31:0]   exp_rd_q[$];
  logic [31:0]   model [logic [29:0]];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_val(input logic [29:0] wa);
    if (model.exists(wa)) return model[wa];
    return 32'hA000_0000 + ({2'b00, wa} - 32'h40);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: ack two cycles after a request is seen, one-cycle pulse.
  initial begin
    int age;
    age = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || mem_ack) begin
        mem_ack = 1'b0;
        age = 0;
      end else if (mem_req) begin
        age++;
        if (age >= 2) begin
          mem_ack = 1'b1;
          ack_cnt++;
          if (mem_we) model[mem_addr] = mem_wdata;
          else mem_rdata = mem_val(mem_addr);
        end
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: memory transactions and completed reads against the expected queues.
  initial begin
    logic [MW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && mem_req && mem_ack) begin
        check("ready_low_in_burst", {31'h0, memReady}, 32'h0);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mem_txn: unexpected we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (mem_we !== e[62] || mem_addr !== e[61:32] || (e[62] && mem_wdata !== e[31:0])) begin
            errors++;
            $display("FAIL mem_txn: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                     mem_we, mem_addr, mem_wdata, e[62], e[61:32], e[31:0]);
          end
        end
      end
      if (!reset && ren && !wen && memReady) begin
        if (exp_rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_data: unexpected completion data=%h", dataout);
        end else begin
          check("read_data", dataout, exp_rd_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] bsv, output int lat);
    address = a; datain = d; byte_select_vector = bsv; wen = w; ren = !w; lat = 0;
    forever begin
      @(negedge clk);
      if (memReady) break;
      lat++;
      if (lat > 400) begin
        checks++; errors++;
        $display("FAIL access_timeout: addr %h got no memReady expected within 400 cycles", a);
        break;
      end
    end
    @(posedge clk);
    #2;
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, output int lat);
    exp_rd_q.push_back(exp);
    access(1'b0, a, 32'h0, 4'h0, lat);
  endtask

  task automatic exp_refill(input logic [29:0] base);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, base + 30'(i), 32'h0});
  endtask

  task automatic exp_wb(input logic [29:0] base, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
    exp_q.push_back({1'b1, base,          d0});
    exp_q.push_back({1'b1, base + 30'd1,  d1});
    exp_q.push_back({1'b1, base + 30'd2,  d2});
    exp_q.push_back({1'b1, base + 30'd3,  d3});
  endtask

  task automatic check_counts(input string name, input int hits, input int misses);
    check({name, "_hits"},   {28'h0, hit_count},  32'(hits));
    check({name, "_misses"}, {28'h0, miss_count}, 32'(misses));
  endtask

  initial begin
    int lat, n, a0;
    reset = 1'b1; address = 0; datain = 0; wen = 0; ren = 0; flush = 0; byte_select_vector = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready",   {31'h0, memReady}, 32'h1);
    check("reset_mem_req", {31'h0, mem_req},  32'h0);
    check("reset_dataout", dataout,           32'h0);
    check("reset_state",   {29'h0, state_dbg}, 32'h0);
    check_counts("reset", 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // cold read miss with 4-word refill
    exp_refill(30'h40);
    do_read(32'h100, 32'hA000_0000, lat);
    check_counts("cold_read", 0, 1);
    check("cold_read_drained", 32'(exp_q.size()), 32'h0);

    // hit on the refilled line, zero latency
    do_read(32'h104, 32'hA000_0001, lat);
    check("hit_latency", 32'(lat), 32'h0);
    check_counts("hit", 1, 1);

    // byte-masked write hit, readback, then dirty eviction
    access(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, lat);
    check("write_hit_latency", 32'(lat), 32'h0);
    do_read(32'h100, 32'hA000_BEEF, lat);
    exp_wb(30'h40, 32'hA000_BEEF, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
    exp_refill(30'h140);
    do_read(32'h500, 32'hA000_0100, lat);
    check_counts("evict", 3, 2);
    check("evict_drained", 32'(exp_q.size()), 32'h0);

    // two dirty lines, then flush
    access(1'b1, 32'h500, 32'h1111_2222, 4'b1111, lat);
    exp_refill(30'h44);
    access(1'b1, 32'h110, 32'h3333_4444, 4'b1111, lat);
    check_counts("pre_flush", 4, 3);
    exp_wb(30'h140, 32'h1111_2222, 32'hA000_0101, 32'hA000_0102, 32'hA000_0103);
    exp_wb(30'h44,  32'h3333_4444, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007);
    a0 = ack_cnt;
    flush = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (memReady) break;
      n++;
      if (n > 2000) begin
        checks++; errors++;
        $display("FAIL flush_timeout: memReady still 0 after %0d cycles", n);
        break;
      end
    end
    check("flush_words", 32'(ack_cnt - a0), 32'd8);
    check("flush_drained", 32'(exp_q.size()), 32'h0);
    @(posedge clk);
    #2;
    exp_refill(30'h140);
    do_read(32'h500, 32'h1111_2222, lat);
    exp_refill(30'h44);
    do_read(32'h110, 32'h3333_4444, lat);
    check_counts("post_flush", 4, 5);

    // reset in the middle of a refill
    exp_q.push_back({1'b0, 30'h80, 32'h0});
    exp_q.push_back({1'b0, 30'h81, 32'h0});
    a0 = ack_cnt;
    address = 32'h200; ren = 1'b1;
    n = 0;
    while (ack_cnt < a0 + 2 && n < 400) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL reset_wait: got %0d acks expected 2", ack_cnt - a0);
    end
    @(posedge clk);
    #2;
    reset = 1'b1; ren = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midburst_mem_req", {31'h0, mem_req},  32'h0);
    check("midburst_ready",   {31'h0, memReady}, 32'h1);
    check_counts("midburst", 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("midburst_drained", 32'(exp_q.size()), 32'h0);
    exp_refill(30'h80);
    do_read(32'h200, 32'hA000_0040, lat);
    check_counts("reread", 0, 1);

    // miss counter saturation
    for (int k = 1; k <= 16; k++) begin
      exp_refill(30'(k << 10));
      do_read(32'(k << 12), mem_val(30'(k << 10)), lat);
      if (k == 14) check("miss_at_15", {28'h0, miss_count}, 32'hF);
    end
    check_counts("saturate", 0, 15);

    check("final_mem_q", 32'(exp_q.size()), 32'h0);
    check("final_rd_q",  32'(exp_rd_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
